// File: rtl/dadda_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package dadda_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RSP
  } sched_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/if_multiplier.sv
// Operand/result bundle for a combinational WIDTH x WIDTH multiplier.
// {overflow,out} together form the full 2*WIDTH-bit product.
interface if_multiplier #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-2:0] out;
  logic               overflow;

  modport mul (
    input  in1,
    input  in2,
    output out,
    output overflow
  );

  modport ctl (
    output in1,
    output in2,
    input  out,
    input  overflow
  );
endinterface

// File: rtl/dadda_6.sv
// 6x6 unsigned carry-save reduction multiplier.
// Partial products compress 6 -> 4 -> 3 -> 2 rows, then one final add.
module dadda_6 (
  if_multiplier.mul muif
);
  localparam int W = 6;
  localparam int P = 2 * W;

  logic [P-1:0] pp [W];
  logic [P-1:0] s0, c0, s1, c1;
  logic [P-1:0] s2, c2, s3, c3;
  logic [P-1:0] sum;

  function automatic logic [2*P-1:0] csa(
    input logic [P-1:0] x,
    input logic [P-1:0] y,
    input logic [P-1:0] z
  );
    logic [P-1:0] s;
    logic [P-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  always_comb begin
    for (int i = 0; i < W; i++)
      pp[i] = P'(muif.in1 & {W{muif.in2[i]}}) << i;
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], pp[5]);
    {c2, s2} = csa(s0, c0, s1);
    {c3, s3} = csa(s2, c2, c1);
    sum = s3 + c3;
  end

  assign muif.out      = sum[P-2:0];
  assign muif.overflow = sum[P-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Produces a one-hot grant plus its index.
module rr_arbiter
  import dadda_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int j;

  // Walk from the farthest offset down so the nearest request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dadda_mul_sched.sv
// Round-robin scheduler sharing one combinational multiplier among
// N_REQ requesters; one operation in flight, valid/ready response.
module dadda_mul_sched
  import dadda_sched_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int N_REQ = 4,
  localparam int ID_W  = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_prod,
  output logic                   rsp_ovf,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  sched_state_e state_q, state_d;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               ovf_q, ovf_d;
  logic               vld_q, vld_d;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;

  if_multiplier #(.WIDTH(WIDTH)) muif ();

  dadda_6 u_mul (
    .muif(muif)
  );

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign muif.in1  = opa_q;
  assign muif.in2  = opb_q;
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = vld_q;
  assign rsp_prod  = prod_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = rsp_id_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    rsp_id_d = rsp_id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    vld_d    = vld_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          opa_d    = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
          opb_d    = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
          gnt_id_d = gnt_idx;
          rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0
                   : gnt_idx + 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        prod_d   = {muif.overflow, muif.out};
        ovf_d    = muif.overflow;
        rsp_id_d = gnt_id_q;
        vld_d    = 1'b1;
        state_d  = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      rsp_id_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      rsp_id_q <= rsp_id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
    end
  end

endmodule

// File: tb/tb_dadda_mul_sched.sv
// Bench for dadda_mul_sched: cycle model compare plus directed
// literal checks and a constrained-random protocol phase.
module tb_dadda_mul_sched;
  localparam int W  = 6;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_prod;
  logic           rsp_ovf;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dadda_mul_sched #(.WIDTH(W), .N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_prod (rsp_prod),
    .rsp_ovf  (rsp_ovf),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing, 2 presenting.
  int m_ph = 0, m_ptr = 0, m_pid = 0, m_id = 0;
  int m_prod = 0, m_pprod = 0;
  bit cnt_on = 1'b0;
  int n_acc = 0, n_rsp = 0;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = -1;
    er = '0;
    if (m_ph == 0)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) er[g] = 1'b1;
    chk("m_req_ready", 32'(req_ready), 32'(er));
    chk("m_busy", 32'(busy), 32'(m_ph != 0));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
    chk("m_rsp_prod", 32'(rsp_prod), m_prod);
    chk("m_rsp_ovf", 32'(rsp_ovf), 32'(m_prod >= (1 << (2*W-1))));
    chk("m_rsp_id", 32'(rsp_id), m_id);
    if (cnt_on) begin
      n_acc += $countones(req_ready & req_valid);
      n_rsp += int'(rsp_valid & rsp_ready);
    end
    if (!rst_n) begin
      m_ph = 0; m_ptr = 0; m_prod = 0; m_id = 0;
    end else if (m_ph == 0) begin
      if (g >= 0) begin
        m_pprod = int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]);
        m_pid   = g;
        m_ptr   = (g + 1) % N;
        m_ph    = 1;
      end
    end else if (m_ph == 1) begin
      m_prod = m_pprod;
      m_id   = m_pid;
      m_ph   = 2;
    end else if (rsp_ready) begin
      m_ph = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic wait_rsp(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) ok = 1'b1;
    end
    chk({nm, "_rsp_seen"}, 32'(ok), 32'd1);
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 63;
    return int'($urandom_range(0, 63));
  endfunction

  int exp_p [N] = '{45, 561, 2562, 3906};
  logic [N-1:0] acc;

  initial begin
    step();
    step();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_prod", 32'(rsp_prod), 0);

    // 1: single request, immediate grant
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 63, 1);
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_rsp("t1");
    chk("t1_prod", 32'(rsp_prod), 63);
    chk("t1_ovf", 32'(rsp_ovf), 0);
    chk("t1_id", 32'(rsp_id), 0);
    step();

    // 2: max operands, one-cycle response
    req_valid = 4'b0100;
    set_req(2, 63, 63);
    #1 chk("t2_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    wait_rsp("t2");
    chk("t2_prod", 32'(rsp_prod), 3969);
    chk("t2_ovf", 32'(rsp_ovf), 1);
    chk("t2_id", 32'(rsp_id), 2);
    @(negedge clk);
    chk("t2_one_cycle", 32'(rsp_valid), 0);

    // 4: pointer at 3, wrap to requester 0, then 0 vs 1
    step();
    req_valid = 4'b0001;
    set_req(0, 21, 3);
    #1 chk("t4_wrap_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0011;
    set_req(0, 4, 5);
    set_req(1, 6, 7);
    wait_rsp("t4a");
    chk("t4a_prod", 32'(rsp_prod), 63);
    chk("t4a_id", 32'(rsp_id), 0);
    step();
    #1 chk("t4_contention", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    wait_rsp("t4b");
    chk("t4b_prod", 32'(rsp_prod), 42);
    chk("t4b_id", 32'(rsp_id), 1);
    step();

    // 3: all requesting continuously from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 5, 9);
    set_req(1, 17, 33);
    set_req(2, 42, 61);
    set_req(3, 63, 62);
    req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_rsp("t3");
      chk("t3_id", 32'(rsp_id), 32'(r % N));
      chk("t3_prod", 32'(rsp_prod), exp_p[r % N]);
      step();
    end
    req_valid = '0;

    // 5: back-pressure for 10 cycles
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 7, 9);
    step();
    req_valid = 4'b0001;
    set_req(0, 2, 3);
    wait_rsp("t5");
    chk("t5_prod", 32'(rsp_prod), 63);
    chk("t5_id", 32'(rsp_id), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(rsp_valid), 1);
      chk("t5_hold_prod", 32'(rsp_prod), 63);
      chk("t5_hold_ready", 32'(req_ready), 0);
      chk("t5_hold_busy", 32'(busy), 1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    step();
    #1 chk("t5_new_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_rsp("t5b");
    chk("t5b_prod", 32'(rsp_prod), 6);
    chk("t5b_id", 32'(rsp_id), 0);
    step();

    // 6: reset while the multiplier is busy
    req_valid = 4'b0010;
    set_req(1, 11, 13);
    step();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", 32'(rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_prod", 32'(rsp_prod), 0);
    chk("t6_id", 32'(rsp_id), 0);
    chk("t6_ovf", 32'(rsp_ovf), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_dropped", 32'(rsp_valid), 0);
    end
    step();
    req_valid = 4'b0101;
    set_req(0, 3, 3);
    set_req(2, 5, 5);
    #1 chk("t6_ptr_reset", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_rsp("t6b");
    chk("t6b_prod", 32'(rsp_prod), 9);
    step();

    // Random protocol-respecting traffic
    cnt_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          set_req(i, pick(), pick());
        end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    cnt_on = 1'b0;
    chk("rnd_acc_nonzero", 32'(n_acc > 0), 1);
    chk("rnd_grant_count", n_rsp, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
